// File: rtl/rcp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rcp_pkg
// Purpose  : Shared types and constants for the reciprocal requester slice:
//            requester FSM state encoding, default SQ(M).(N) operand width,
//            saturation value and timeout counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rcp_pkg;

  // Default operand format SQ(12).(12)
  localparam int c_rcp_m = 12;
  localparam int c_rcp_n = 12;
  localparam int c_rcp_w = c_rcp_m + c_rcp_n;

  // Largest positive SQ value, substituted when a reciprocal cannot be formed
  localparam logic [c_rcp_w-1:0] c_rcp_sat = {1'b0, {(c_rcp_w-1){1'b1}}};

  // Width of the done-wait watchdog counter (TIMEOUT must fit in it)
  localparam int c_tmo_w = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_X  = 3'd1,
    WAIT_X = 3'd2,
    REQ_Y  = 3'd3,
    WAIT_Y = 3'd4,
    HOLD   = 3'd5
  } rcp_state_t;

endpackage : rcp_pkg
`default_nettype wire

// File: rtl/rcp_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rcp_watchdog
// Purpose  : Load/decrement/expire counter bounding how long the requester
//            waits for the reciprocal device's done.
// Ports    : i_clk      clock
//            i_reset_n  asynchronous active-low reset
//            i_load     load TIMEOUT (asserted on the cycle before a wait)
//            i_dec      decrement (asserted while waiting)
//            o_expire   last permitted wait cycle without done
// Revision : 1.0 - initial release
// ============================================================================
module rcp_watchdog
  import rcp_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expire
);

  localparam logic [c_tmo_w-1:0] c_load = c_tmo_w'(TIMEOUT);

  logic [c_tmo_w-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_load;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Counter holds TIMEOUT in the first wait cycle, so it reads 1 in the
  // TIMEOUT-th wait cycle; expiring there gives exactly TIMEOUT wait cycles.
  assign o_expire = i_dec && (r_cnt == c_tmo_w'(1));

endmodule : rcp_watchdog
`default_nettype wire

// File: rtl/rcp_requester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rcp_requester
// Purpose  : Drives the sequential reciprocal device's start/done handshake
//            for an (X, Y) ray-direction pair and returns both reciprocals
//            with saturation flags as one registered valid/ready transfer.
// Ports    : i_clk, i_reset_n         clock, async active-low reset
//            i_valid/o_ready          upstream operand handshake
//            i_x, i_y, i_abs          operands and abs-mode request
//            o_start, o_rcp_data,
//            o_rcp_abs                request side of the device
//            i_rcp_data, i_rcp_sat,
//            i_rcp_done               response side of the device
//            o_valid/i_ready          downstream result handshake
//            o_rx, o_ry, o_sat_x,
//            o_sat_y                  results
//            o_err                    done timeout seen (sticky to next accept)
// Config   : RCP_REQ_TIMEOUT_EN - enables the done-wait watchdog and o_err;
//            when undefined WAIT states wait indefinitely and o_err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module rcp_requester
  import rcp_pkg::*;
#(
  parameter int M       = 12,
  parameter int N       = 12,
  parameter int TIMEOUT = 15
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [M+N-1:0] i_x,
  input  logic [M+N-1:0] i_y,
  input  logic           i_abs,
  output logic           o_start,
  output logic [M+N-1:0] o_rcp_data,
  output logic           o_rcp_abs,
  input  logic [M+N-1:0] i_rcp_data,
  input  logic           i_rcp_sat,
  input  logic           i_rcp_done,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [M+N-1:0] o_rx,
  output logic [M+N-1:0] o_ry,
  output logic           o_sat_x,
  output logic           o_sat_y,
  output logic           o_err
);

  localparam int              c_w   = M + N;
  localparam logic [c_w-1:0]  c_sat = {1'b0, {(c_w-1){1'b1}}};

  rcp_state_t      r_state;
  logic [c_w-1:0]  r_x;
  logic [c_w-1:0]  r_y;
  logic            w_expire;

`ifdef RCP_REQ_TIMEOUT_EN
  logic w_wd_load;
  logic w_wd_dec;
  logic r_err;

  // Load on the REQ cycle that issues a start, i.e. right before WAIT.
  assign w_wd_load = ((r_state == REQ_X) && (r_x != '0)) ||
                     ((r_state == REQ_Y) && (r_y != '0));
  assign w_wd_dec  = (r_state == WAIT_X) || (r_state == WAIT_Y);

  rcp_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (w_wd_load),
    .i_dec     (w_wd_dec),
    .o_expire  (w_expire)
  );

  assign o_err = r_err;
`else
  assign w_expire = 1'b0;
  assign o_err    = 1'b0;
`endif

  // o_start is raised on the edge that enters REQ_x, so the device samples it
  // at the edge that enters WAIT_x. The device clears its done on that same
  // edge, so the first done sample in WAIT_x is already the fresh value.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      o_ready    <= 1'b0;
      o_start    <= 1'b0;
      o_rcp_data <= '0;
      o_rcp_abs  <= 1'b0;
      o_valid    <= 1'b0;
      o_rx       <= '0;
      o_ry       <= '0;
      o_sat_x    <= 1'b0;
      o_sat_y    <= 1'b0;
`ifdef RCP_REQ_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
    end else begin
      o_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!o_ready) begin
            // First cycle after reset or after a result handoff
            o_ready <= 1'b1;
          end else if (i_valid) begin
            o_ready   <= 1'b0;
            r_x       <= i_x;
            r_y       <= i_y;
            o_rcp_abs <= i_abs;
`ifdef RCP_REQ_TIMEOUT_EN
            r_err     <= 1'b0;
`endif
            if (i_x != '0) begin
              o_start    <= 1'b1;
              o_rcp_data <= i_x;
            end
            r_state <= REQ_X;
          end
        end

        REQ_X: begin
          if (r_x == '0) begin
            o_rx    <= c_sat;
            o_sat_x <= 1'b1;
            if (r_y != '0) begin
              o_start    <= 1'b1;
              o_rcp_data <= r_y;
            end
            r_state <= REQ_Y;
          end else begin
            r_state <= WAIT_X;
          end
        end

        WAIT_X: begin
          if (i_rcp_done || w_expire) begin
            o_rx    <= i_rcp_done ? i_rcp_data : c_sat;
            o_sat_x <= i_rcp_done ? i_rcp_sat  : 1'b1;
`ifdef RCP_REQ_TIMEOUT_EN
            if (!i_rcp_done) r_err <= 1'b1;
`endif
            if (r_y != '0) begin
              o_start    <= 1'b1;
              o_rcp_data <= r_y;
            end
            r_state <= REQ_Y;
          end
        end

        REQ_Y: begin
          if (r_y == '0) begin
            o_ry    <= c_sat;
            o_sat_y <= 1'b1;
            o_valid <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_state <= WAIT_Y;
          end
        end

        WAIT_Y: begin
          if (i_rcp_done || w_expire) begin
            o_ry    <= i_rcp_done ? i_rcp_data : c_sat;
            o_sat_y <= i_rcp_done ? i_rcp_sat  : 1'b1;
`ifdef RCP_REQ_TIMEOUT_EN
            if (!i_rcp_done) r_err <= 1'b1;
`endif
            o_valid <= 1'b1;
            r_state <= HOLD;
          end
        end

        HOLD: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : rcp_requester
`default_nettype wire

// File: tb/tb_rcp_requester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rcp_requester
// Purpose  : Directed self-checking bench for rcp_requester with a 4-cycle
//            reciprocal device responder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rcp_requester;

  localparam int c_w = 24;
  localparam logic [c_w-1:0] c_sat = 24'h7FFFFF;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_valid = 1'b0;
  logic           o_ready;
  logic [c_w-1:0] i_x = '0;
  logic [c_w-1:0] i_y = '0;
  logic           i_abs = 1'b0;
  logic           o_start;
  logic [c_w-1:0] o_rcp_data;
  logic           o_rcp_abs;
  logic [c_w-1:0] i_rcp_data;
  logic           i_rcp_sat;
  logic           i_rcp_done;
  logic           o_valid;
  logic           i_ready = 1'b0;
  logic [c_w-1:0] o_rx;
  logic [c_w-1:0] o_ry;
  logic           o_sat_x;
  logic           o_sat_y;
  logic           o_err;

  // Responder model state
  logic           dev_done = 1'b0;
  logic           dev_sat = 1'b0;
  logic [c_w-1:0] dev_res = '0;
  logic [c_w-1:0] dev_op = '0;
  logic           dev_busy = 1'b0;
  int             dev_cnt = 0;
  int             n_starts = 0;
  logic           set_stale = 1'b0;
  logic           sat_noise = 1'b0;
  logic           dev_hang = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  assign i_rcp_done = dev_done;
  assign i_rcp_sat  = dev_sat | sat_noise;
  assign i_rcp_data = dev_res;

  always #5 clk = ~clk;

  rcp_requester #(
    .M       (12),
    .N       (12),
    .TIMEOUT (15)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_x        (i_x),
    .i_y        (i_y),
    .i_abs      (i_abs),
    .o_start    (o_start),
    .o_rcp_data (o_rcp_data),
    .o_rcp_abs  (o_rcp_abs),
    .i_rcp_data (i_rcp_data),
    .i_rcp_sat  (i_rcp_sat),
    .i_rcp_done (i_rcp_done),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_rx       (o_rx),
    .o_ry       (o_ry),
    .o_sat_x    (o_sat_x),
    .o_sat_y    (o_sat_y),
    .o_err      (o_err)
  );

  function automatic logic [c_w:0] dev_lookup(input logic [c_w-1:0] op);
    // {sat, result}
    case (op)
      24'h002000: dev_lookup = {1'b0, 24'h000800};
      24'h004000: dev_lookup = {1'b0, 24'h000400};
      24'h000001: dev_lookup = {1'b1, 24'h7FFFFF};
      default:    dev_lookup = {1'b0, 24'h123456};
    endcase
  endfunction

  // Device: start clears done; done rises on the third edge after the start
  // edge. It has no connection to the requester's reset on purpose, so a
  // response can arrive after the requester was reset.
  always @(posedge clk) begin
    if (o_start) begin
      dev_done <= 1'b0;
      dev_busy <= 1'b1;
      dev_cnt  <= 3;
      dev_op   <= o_rcp_data;
      n_starts <= n_starts + 1;
    end else if (dev_busy) begin
      if (dev_cnt == 1) begin
        if (!dev_hang) begin
          dev_done <= 1'b1;
          {dev_sat, dev_res} <= dev_lookup(dev_op);
        end
        dev_busy <= 1'b0;
      end
      dev_cnt <= dev_cnt - 1;
    end else if (set_stale) begin
      dev_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack();
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check("ack_valid_low", {31'd0, o_valid}, 32'd0);
    check("ack_ready_high", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic run_txn(input logic [c_w-1:0] x, input logic [c_w-1:0] y,
                         input logic abs, input int exp_lat,
                         input logic [c_w-1:0] erx, input logic [c_w-1:0] ery,
                         input logic esx, input logic esy,
                         input int exp_starts, input logic eerr,
                         input logic do_ack);
    int s0;
    int cyc;
    @(negedge clk);
    check("ready_before", {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_x     = x;
    i_y     = y;
    i_abs   = abs;
    s0      = n_starts;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("ready_drop", {31'd0, o_ready}, 32'd0);
    check("err_clear", {31'd0, o_err}, 32'd0);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (o_valid) break;
    end
    check("latency", cyc, exp_lat);
    check("rx", {8'd0, o_rx}, {8'd0, erx});
    check("ry", {8'd0, o_ry}, {8'd0, ery});
    check("sat_x", {31'd0, o_sat_x}, {31'd0, esx});
    check("sat_y", {31'd0, o_sat_y}, {31'd0, esy});
    check("starts", n_starts - s0, exp_starts);
    check("rcp_abs", {31'd0, o_rcp_abs}, {31'd0, abs});
    check("err", {31'd0, o_err}, {31'd0, eerr});
    if (do_ack) ack();
  endtask

  initial begin
    int s1;
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_start", {31'd0, o_start}, 32'd0);
    check("rst_rx", {8'd0, o_rx}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, o_ready}, 32'd1);

    // ---------------- basic two-request transaction ----------------
    run_txn(24'h002000, 24'h004000, 1'b1, 11, 24'h000800, 24'h000400,
            1'b0, 1'b0, 2, 1'b0, 1'b1);

    // ---------------- zero X: saturate, one start ----------------
    run_txn(24'h000000, 24'h002000, 1'b0, 7, c_sat, 24'h000800,
            1'b1, 1'b0, 1, 1'b0, 1'b1);

    // ---------------- zero Y ----------------
    run_txn(24'h004000, 24'h000000, 1'b0, 7, 24'h000400, c_sat,
            1'b0, 1'b1, 1, 1'b0, 1'b1);

    // ---------------- device sat flag + HOLD back-pressure ----------------
    run_txn(24'h000001, 24'h004000, 1'b0, 11, c_sat, 24'h000400,
            1'b1, 1'b0, 2, 1'b0, 1'b0);
    s1 = n_starts;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_x     = 24'h002000;
      i_y     = 24'h002000;
      check("hold_valid", {31'd0, o_valid}, 32'd1);
      check("hold_ready", {31'd0, o_ready}, 32'd0);
      check("hold_rx", {8'd0, o_rx}, {8'd0, c_sat});
      check("hold_ry", {8'd0, o_ry}, 32'h000400);
    end
    i_valid = 1'b0;
    check("hold_no_start", n_starts - s1, 0);
    ack();

    // ---------------- stale done and sat noise in IDLE ----------------
    @(negedge clk);
    set_stale = 1'b1;
    @(negedge clk);
    set_stale = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sat_noise = i[0];
      @(negedge clk);
      check("stale_ready", {31'd0, o_ready}, 32'd1);
      check("stale_start", {31'd0, o_start}, 32'd0);
      check("stale_valid", {31'd0, o_valid}, 32'd0);
    end
    sat_noise = 1'b0;
    run_txn(24'h002000, 24'h004000, 1'b0, 11, 24'h000800, 24'h000400,
            1'b0, 1'b0, 2, 1'b0, 1'b1);

    // ---------------- async reset during WAIT_Y ----------------
    @(negedge clk);
    i_valid = 1'b1;
    i_x     = 24'h002000;
    i_y     = 24'h004000;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, o_ready}, 32'd0);
    check("arst_valid", {31'd0, o_valid}, 32'd0);
    check("arst_start", {31'd0, o_start}, 32'd0);
    check("arst_data", {8'd0, o_rcp_data}, 32'd0);
    check("arst_rx", {8'd0, o_rx}, 32'd0);
    check("arst_satx", {31'd0, o_sat_x}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("late_done_valid", {31'd0, o_valid}, 32'd0);
      check("late_done_start", {31'd0, o_start}, 32'd0);
    end
    check("late_done_ready", {31'd0, o_ready}, 32'd1);
    run_txn(24'h004000, 24'h002000, 1'b1, 11, 24'h000400, 24'h000800,
            1'b0, 1'b0, 2, 1'b0, 1'b1);

`ifdef RCP_REQ_TIMEOUT_EN
    // ---------------- done never arrives ----------------
    dev_hang = 1'b1;
    run_txn(24'h002000, 24'h004000, 1'b0, 33, c_sat, c_sat,
            1'b1, 1'b1, 2, 1'b1, 1'b1);
    dev_hang = 1'b0;
    check("err_sticky_idle", {31'd0, o_err}, 32'd1);
    run_txn(24'h002000, 24'h004000, 1'b0, 11, 24'h000800, 24'h000400,
            1'b0, 1'b0, 2, 1'b0, 1'b1);
`else
    check("err_tied", {31'd0, o_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global watchdog so the bench always ends on its own
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule : tb_rcp_requester
`default_nettype wire
